// File: rtl/sgpr_pkg.sv
// Shared SGPR write-path constants and queue entry layout.
// Imported by the write-queue FIFO and its per-FU wrapper.
package sgpr_pkg;

    localparam int SGPR_ADDR_W = 9;
    localparam int SGPR_DATA_W = 64;
    localparam int WFID_W      = 6;

    typedef struct packed {
        logic [SGPR_ADDR_W-1:0] addr;
        logic [SGPR_DATA_W-1:0] data;
        logic [SGPR_DATA_W-1:0] mask;
        logic [WFID_W-1:0]      wfid;
        logic                   last;
    } sgpr_wr_entry_t;

endpackage

// File: rtl/sgpr_wrq_fifo.sv
// Circular buffer of SGPR write entries with push/pop and occupancy.
// Entry storage is left unreset; only pointers and count clear.
module sgpr_wrq_fifo
    import sgpr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  sgpr_wr_entry_t push_entry,
    input  logic           pop,
    output sgpr_wr_entry_t head,
    output logic [CNT_W-1:0] count,
    output logic           full,
    output logic           empty
);

    localparam int PTR_W = $clog2(DEPTH);

    sgpr_wr_entry_t   mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sgpr_fu_wr_queue.sv
// Per-FU SGPR write-back initiator: buffers results, requests the
// register-file port, and signals instruction completion.
module sgpr_fu_wr_queue
    import sgpr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   res_valid,
    output logic                   res_ready,
    input  logic [SGPR_ADDR_W-1:0] res_addr,
    input  logic [SGPR_DATA_W-1:0] res_data,
    input  logic [SGPR_DATA_W-1:0] res_mask,
    input  logic [WFID_W-1:0]      res_wfid,
    input  logic                   res_last,
    output logic                   arb_req,
    input  logic                   arb_select,
    output logic                   wr_en,
    output logic [SGPR_ADDR_W-1:0] wr_addr,
    output logic [SGPR_DATA_W-1:0] wr_data,
    output logic [SGPR_DATA_W-1:0] wr_mask,
    output logic                   instr_done,
    output logic [WFID_W-1:0]      instr_done_wfid,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   err_overflow
);

    sgpr_wr_entry_t in_entry;
    sgpr_wr_entry_t head;
    logic           full;
    logic           empty;
    logic           push;

    assign in_entry = '{
        addr: res_addr,
        data: res_data,
        mask: res_mask,
        wfid: res_wfid,
        last: res_last
    };

    // No look-ahead to a same-cycle pop: a full queue refuses.
    assign res_ready = ~full;
    assign push      = res_valid & res_ready;
    assign arb_req   = ~empty;
    assign wr_en     = arb_select & ~empty;
    assign wr_addr   = empty ? '0 : head.addr;
    assign wr_data   = empty ? '0 : head.data;
    assign wr_mask   = empty ? '0 : head.mask;

    sgpr_wrq_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (in_entry),
        .pop        (wr_en),
        .head       (head),
        .count      (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_done      <= 1'b0;
            instr_done_wfid <= '0;
            err_overflow    <= 1'b0;
        end else begin
            instr_done <= wr_en & head.last;
            if (wr_en & head.last) begin
                instr_done_wfid <= head.wfid;
            end
            if (res_valid & ~res_ready) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sgpr_fu_wr_queue.sv
// Directed self-checking bench for sgpr_fu_wr_queue.
module tb_sgpr_fu_wr_queue;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  res_addr;
    logic [63:0] res_data;
    logic [63:0] res_mask;
    logic [5:0]  res_wfid;
    logic        res_last;
    logic        arb_req;
    logic        arb_select;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic [63:0] wr_mask;
    logic        instr_done;
    logic [5:0]  instr_done_wfid;
    logic [2:0]  occupancy;
    logic        err_overflow;

    int n_checks;
    int n_fail;

    sgpr_fu_wr_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_addr        (res_addr),
        .res_data        (res_data),
        .res_mask        (res_mask),
        .res_wfid        (res_wfid),
        .res_last        (res_last),
        .arb_req         (arb_req),
        .arb_select      (arb_select),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_mask         (wr_mask),
        .instr_done      (instr_done),
        .instr_done_wfid (instr_done_wfid),
        .occupancy       (occupancy),
        .err_overflow    (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] a, input logic [63:0] d,
                        input logic [63:0] m, input logic [5:0] w,
                        input logic l);
        res_addr  = a;
        res_data  = d;
        res_mask  = m;
        res_wfid  = w;
        res_last  = l;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        arb_select = 1'b1;
        #1;
        n_checks++;
        if (res_ready !== 1'b1 || arb_req !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: ready=%b req=%b wr_en=%b want 1 0 0",
                     res_ready, arb_req, wr_en);
        end
        n_checks++;
        if (wr_addr !== 9'h0 || wr_data !== 64'h0 || wr_mask !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_port: addr=%h data=%h mask=%h want 0",
                     wr_addr, wr_data, wr_mask);
        end
        n_checks++;
        if (occupancy !== 3'd0 || instr_done !== 1'b0 ||
            instr_done_wfid !== 6'd0 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: occ=%0d done=%b wfid=%0d ovf=%b want 0",
                     occupancy, instr_done, instr_done_wfid, err_overflow);
        end
        arb_select = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        push(9'h010, 64'hDEAD_BEEF_0000_0001, '1, 6'd5, 1'b1);
        n_checks++;
        if (arb_req !== 1'b1 || occupancy !== 3'd1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_req: req=%b occ=%0d wr_en=%b want 1 1 0",
                     arb_req, occupancy, wr_en);
        end
        arb_select = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'h010 ||
            wr_data !== 64'hDEAD_BEEF_0000_0001 || wr_mask !== '1) begin
            n_fail++;
            $display("FAIL single_wr: en=%b addr=%h data=%h mask=%h",
                     wr_en, wr_addr, wr_data, wr_mask);
        end
        tick();
        arb_select = 1'b0;
        n_checks++;
        if (instr_done !== 1'b1 || instr_done_wfid !== 6'd5 ||
            occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL single_done: done=%b wfid=%0d occ=%0d want 1 5 0",
                     instr_done, instr_done_wfid, occupancy);
        end
        tick();
        n_checks++;
        if (instr_done !== 1'b0 || instr_done_wfid !== 6'd5) begin
            n_fail++;
            $display("FAIL single_pulse: done=%b wfid=%0d want 0 5",
                     instr_done, instr_done_wfid);
        end
    endtask

    task automatic test_empty_grant();
        arb_select = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 9'h0) begin
            n_fail++;
            $display("FAIL empty_grant: wr_en=%b addr=%h want 0 0",
                     wr_en, wr_addr);
        end
        tick();
        tick();
        n_checks++;
        if (occupancy !== 3'd0 || instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_state: occ=%0d done=%b want 0 0",
                     occupancy, instr_done);
        end
        arb_select = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            push(9'h020 + 9'(i), 64'h1111_0000_0000_0000 + 64'(i),
                 64'h0000_FFFF_0000_0000 + 64'(i), 6'(i), 1'b0);
        end
        n_checks++;
        if (occupancy !== 3'd4 || res_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full: occ=%0d ready=%b want 4 0",
                     occupancy, res_ready);
        end
        push(9'h1FF, 64'hBAD, '1, 6'd63, 1'b1);
        n_checks++;
        if (err_overflow !== 1'b1 || occupancy !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b occ=%0d want 1 4",
                     err_overflow, occupancy);
        end
        arb_select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 9'h020 + 9'(i) ||
                wr_data !== 64'h1111_0000_0000_0000 + 64'(i) ||
                wr_mask !== 64'h0000_FFFF_0000_0000 + 64'(i)) begin
                n_fail++;
                $display("FAIL drain%0d: en=%b addr=%h data=%h mask=%h",
                         i, wr_en, wr_addr, wr_data, wr_mask);
            end
            tick();
            n_checks++;
            if (instr_done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_done%0d: done=%b want 0", i, instr_done);
            end
        end
        arb_select = 1'b0;
        n_checks++;
        if (occupancy !== 3'd0 || err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: occ=%0d ovf=%b want 0 1",
                     occupancy, err_overflow);
        end
    endtask

    task automatic test_back_to_back();
        push(9'h040, 64'h40, '1, 6'd1, 1'b0);
        push(9'h041, 64'h41, '1, 6'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            res_addr   = 9'h042 + 9'(k);
            res_data   = 64'h42 + 64'(k);
            res_mask   = '1;
            res_wfid   = 6'd1;
            res_last   = 1'b0;
            res_valid  = 1'b1;
            arb_select = 1'b1;
            #1;
            n_checks++;
            if (wr_en !== 1'b1 || res_ready !== 1'b1 ||
                wr_addr !== 9'h040 + 9'(k) ||
                wr_data !== 64'h40 + 64'(k)) begin
                n_fail++;
                $display("FAIL simul%0d: en=%b rdy=%b addr=%h data=%h",
                         k, wr_en, res_ready, wr_addr, wr_data);
            end
            tick();
            n_checks++;
            if (occupancy !== 3'd2) begin
                n_fail++;
                $display("FAIL simul_occ%0d: occ=%0d want 2", k, occupancy);
            end
        end
        res_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 9'h046 + 9'(k) ||
                wr_data !== 64'h46 + 64'(k)) begin
                n_fail++;
                $display("FAIL wrap%0d: en=%b addr=%h data=%h",
                         k, wr_en, wr_addr, wr_data);
            end
            tick();
        end
        arb_select = 1'b0;
        n_checks++;
        if (occupancy !== 3'd0 || arb_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: occ=%0d req=%b want 0 0",
                     occupancy, arb_req);
        end
    endtask

    task automatic test_last_pattern();
        push(9'h060, 64'h60, '1, 6'd2, 1'b0);
        push(9'h061, 64'h61, '1, 6'd2, 1'b1);
        push(9'h062, 64'h62, '1, 6'd7, 1'b1);
        arb_select = 1'b1;
        tick();
        n_checks++;
        if (instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL last_p1: done=%b want 0", instr_done);
        end
        tick();
        n_checks++;
        if (instr_done !== 1'b1 || instr_done_wfid !== 6'd2) begin
            n_fail++;
            $display("FAIL last_p2: done=%b wfid=%0d want 1 2",
                     instr_done, instr_done_wfid);
        end
        tick();
        arb_select = 1'b0;
        n_checks++;
        if (instr_done !== 1'b1 || instr_done_wfid !== 6'd7) begin
            n_fail++;
            $display("FAIL last_p3: done=%b wfid=%0d want 1 7",
                     instr_done, instr_done_wfid);
        end
        tick();
        n_checks++;
        if (instr_done !== 1'b0 || instr_done_wfid !== 6'd7 ||
            occupancy !== 3'd0) begin
            n_fail++;
            $display("FAIL last_end: done=%b wfid=%0d occ=%0d want 0 7 0",
                     instr_done, instr_done_wfid, occupancy);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            push(9'h080 + 9'(i), 64'h80 + 64'(i), '1, 6'd10 + 6'(i), 1'b1);
        end
        arb_select = 1'b1;
        tick();
        n_checks++;
        if (instr_done !== 1'b1 || instr_done_wfid !== 6'd10 ||
            occupancy !== 3'd3) begin
            n_fail++;
            $display("FAIL pre_rst: done=%b wfid=%0d occ=%0d want 1 10 3",
                     instr_done, instr_done_wfid, occupancy);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (occupancy !== 3'd0 || wr_en !== 1'b0 || instr_done !== 1'b0 ||
            arb_req !== 1'b0 || wr_addr !== 9'h0 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: occ=%0d en=%b done=%b req=%b addr=%h ovf=%b",
                     occupancy, wr_en, instr_done, arb_req, wr_addr,
                     err_overflow);
        end
        arb_select = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        n_checks++;
        if (occupancy !== 3'd0 || instr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst: occ=%0d done=%b want 0 0",
                     occupancy, instr_done);
        end
        push(9'h155, 64'hCAFE_F00D_1234_5678, 64'h00FF_00FF_00FF_00FF,
             6'd33, 1'b1);
        arb_select = 1'b1;
        #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 9'h155 ||
            wr_data !== 64'hCAFE_F00D_1234_5678 ||
            wr_mask !== 64'h00FF_00FF_00FF_00FF) begin
            n_fail++;
            $display("FAIL post_push: en=%b addr=%h data=%h mask=%h",
                     wr_en, wr_addr, wr_data, wr_mask);
        end
        tick();
        arb_select = 1'b0;
        n_checks++;
        if (instr_done !== 1'b1 || instr_done_wfid !== 6'd33) begin
            n_fail++;
            $display("FAIL post_done: done=%b wfid=%0d want 1 33",
                     instr_done, instr_done_wfid);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        res_valid  = 1'b0;
        res_addr   = '0;
        res_data   = '0;
        res_mask   = '0;
        res_wfid   = '0;
        res_last   = 1'b0;
        arb_select = 1'b0;
        tick();
        test_reset();
        test_single();
        test_empty_grant();
        test_overflow();
        test_back_to_back();
        test_last_pattern();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sgpr_fu_wr_queue.md
Name: sgpr_fu_wr_queue

Overview:
- Per-functional-unit write-back initiator for the SGPR register file; one instance per SIMD/SIMF unit.
- Buffers completed scalar results (the 64-bit value, per-bit mask, dest address, wfid) and raises a request to the register-file arbiter.
- When the arbiter's select bit for this unit is high, drives one entry onto the SGPR write port (wr_en/addr/data/mask) that cycle and pops it.
- Reports instruction completion to issue one cycle after the final write of an instruction.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
CNT_W, 3, width of occupancy counter (log2(DEPTH)+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
res_valid  in  1  FU presents a result this cycle
res_ready  out  1  queue can accept; = (count < DEPTH)
res_addr  in  9  SGPR dest address
res_data  in  64  result value
res_mask  in  64  per-bit write mask (1 = write bit)
res_wfid  in  6  wavefront id
res_last  in  1  final SGPR write of this instruction
arb_req  out  1  request to arbiter; = queue non-empty
arb_select  in  1  this unit's bit of the arbiter select vector
wr_en  out  1  SGPR write enable
wr_addr  out  9  SGPR write address
wr_data  out  64  SGPR write data
wr_mask  out  64  SGPR write mask
instr_done  out  1  one-cycle completion pulse
instr_done_wfid  out  6  wfid accompanying instr_done
occupancy  out  CNT_W  current entry count
err_overflow  out  1  sticky: push attempted while full

Behaviour:
- Storage: circular buffer, DEPTH entries of {addr 9, data 64, mask 64, wfid 6, last 1}; rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count CNT_W bits.
- Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, instr_done=0, instr_done_wfid=0, err_overflow=0. Entry contents are not reset. Outputs during reset: res_ready=1, arb_req=0, wr_en=0, wr_addr/data/mask=0 (gated), occupancy=0.
- Push: res_valid & res_ready writes the entry at wr_ptr, then wr_ptr++ and count++. res_ready does not look ahead to a same-cycle pop: when full, the push is refused even if a pop occurs.
- Overflow: res_valid & !res_ready drops the result and sets err_overflow=1 until reset.
- Head presentation: wr_addr/data/mask show the head entry combinationally when count>0, otherwise 0.
- Grant: wr_en = arb_select & (count>0), combinational and same-cycle. The SGPR flops the muxed write port internally, so register-file contents update one cycle later.
  - A grant with wr_en=1 pops the entry: rd_ptr++ and count--.
  - arb_select while empty has no effect: wr_en=0 and no pop.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Push into an empty queue: arb_req rises the next cycle. There is no bypass; minimum latency from res_valid to wr_en is 1 cycle.
- Completion: if the popped entry had last=1, then on the next cycle instr_done=1 and instr_done_wfid = that entry's wfid, for exactly one cycle. Otherwise instr_done=0. instr_done_wfid holds its last value when instr_done=0.
- Back-to-back grants on consecutive last=1 entries give consecutive instr_done pulses, each with its own wfid.
- Ordering: strictly FIFO; no reordering across wfids.
- Reset mid-operation: pending entries are discarded, any instr_done pulse is cancelled, and wr_en falls immediately.

Decomposition:
- Shared package sgpr_pkg holds:
  - constants SGPR_ADDR_W=9, SGPR_DATA_W=64, WFID_W=6
  - typedef sgpr_wr_entry_t {addr, data, mask, wfid, last}
- One sub-module is natural: sgpr_wrq_fifo, a generic DEPTH x entry circular buffer with push/pop/count.
- The top level adds the grant gating, completion pulse and overflow flag.

Test Plan:
- Single push {addr=9'h010, data=64'hDEAD_BEEF_0000_0001, mask=all 1, wfid=5, last=1}, arb_select=1 from cycle 2 -> arb_req=1 at cycle 1; wr_en=1 at cycle 2 with that addr/data; instr_done=1, wfid=5 at cycle 3; occupancy back to 0.
- Push 4 entries with arb_select=0 -> occupancy=4, res_ready=0; a 5th push sets err_overflow=1 and does not change occupancy; then 4 grants drain the entries in push order.
- Simultaneous push and grant at occupancy=2 -> occupancy stays 2, popped data matches the oldest entry, pointers wrap correctly after 6 such cycles.
- arb_select=1 while empty -> wr_en=0, occupancy stays 0, instr_done stays 0.
- Entries with last pattern 0,1,1 (wfids 2,2,7) granted back to back -> instr_done pulses one cycle after the 2nd and 3rd pops with wfids 2 then 7; no pulse after the 1st.
- rst=0 asserted asynchronously mid-cycle with 3 entries pending and instr_done due -> occupancy=0, wr_en=0, instr_done=0 immediately; after release, the first new push is written correctly.
